// File: rtl/hc40103.sv
// 8-bit presettable synchronous down-counter, 74HC40103 pin-compatible.
// Ports keep the device pin numbering; the supply pins p8/p16 have no port.
module hc40103 (
    input  logic p1,   // clock
    input  logic p2,   // MR, synchronous reset, active-high
    input  logic p3,   // TE, terminal enable, active-low
    input  logic p4,   // P0 (LSB)
    input  logic p5,   // P1
    input  logic p6,   // P2
    input  logic p7,   // P3
    input  logic p9,   // PL, synchronous parallel load, active-low
    input  logic p10,  // P4
    input  logic p11,  // P5
    input  logic p12,  // P6
    input  logic p13,  // P7 (MSB)
    input  logic p15,  // PE, synchronous preset enable, active-low
    output logic p14   // TC, terminal count, active-low
);

    logic [7:0] r_cnt = 8'hFF;
    logic [7:0] w_preset;

    assign w_preset = {p13, p12, p11, p10, p7, p6, p5, p4};

    // PL and PE both load the preset; PL only differs in ignoring TE, which
    // the load path never looks at anyway, so the two share one branch.
    always_ff @(posedge p1) begin
        if (p2) begin
            r_cnt <= 8'hFF;
        end else if (!p9 || !p15) begin
            r_cnt <= w_preset;
        end else if (!p3) begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

    assign p14 = ~((r_cnt == 8'h00) && !p3);

endmodule

// File: tb/tb_hc40103.sv
// Directed bench for hc40103: a cycle model checks every cycle, plus
// literal expectations for the reset, preset, inhibit, divider, priority cases.
module tb_hc40103;

    logic       clk = 1'b0;
    logic       p2, p3, p9, pe_drv, tie;
    logic [7:0] pdata;
    logic       p14, p15;
    logic       chk_en = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    // Behavioural model: the counter value and the TC it implies
    int m_cnt = 255;
    logic m_tc;
    logic m_pe;

    always #5 clk = ~clk;

    assign p15  = tie ? p14 : pe_drv;
    assign m_tc = (m_cnt == 0 && p3 == 1'b0) ? 1'b0 : 1'b1;
    assign m_pe = tie ? m_tc : pe_drv;

    hc40103 dut (
        .p1 (clk),
        .p2 (p2),
        .p3 (p3),
        .p4 (pdata[0]),
        .p5 (pdata[1]),
        .p6 (pdata[2]),
        .p7 (pdata[3]),
        .p9 (p9),
        .p10(pdata[4]),
        .p11(pdata[5]),
        .p12(pdata[6]),
        .p13(pdata[7]),
        .p15(p15),
        .p14(p14)
    );

    always @(posedge clk) begin
        if (p2)
            m_cnt <= 255;
        else if (!p9 || !m_pe)
            m_cnt <= int'(pdata);
        else if (!p3)
            m_cnt <= (m_cnt + 255) % 256;
    end

    task automatic check(input string name, input int got, input int exp);
        n_chk++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_tc",  int'(p14), int'(m_tc));
            check("model_cnt", int'(dut.r_cnt), m_cnt);
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        p2 = 1'b1; p3 = 1'b0; p9 = 1'b1; pe_drv = 1'b1; tie = 1'b0; pdata = 8'h00;

        // Reset case: 255 clocks down to 00, 256th wraps to FF
        tick(1);
        chk_en = 1'b1;
        check("reset_tc", int'(p14), 1);
        check("reset_cnt", int'(dut.r_cnt), 8'hFF);
        p2 = 1'b0;
        tick(254);
        check("reset_254", int'(p14), 1);
        tick(1);
        check("reset_255", int'(p14), 0);
        tick(1);
        check("reset_256", int'(p14), 1);

        // Preset case: load 5 via PE, TC low after exactly 5 clocks
        pe_drv = 1'b0; pdata = 8'h05;
        tick(1);
        pe_drv = 1'b1; pdata = 8'hAA;  // must not disturb the loaded count
        tick(4);
        check("preset_4", int'(p14), 1);
        tick(1);
        check("preset_5", int'(p14), 0);
        tick(1);
        check("preset_6", int'(p14), 1);

        // Inhibit case: 00 loaded with TE high holds; TC follows TE immediately
        p9 = 1'b0; pdata = 8'h00; p3 = 1'b1;
        tick(1);
        p9 = 1'b1;
        check("inhibit_tc0", int'(p14), 1);
        tick(10);
        check("inhibit_tc10", int'(p14), 1);
        check("inhibit_cnt", int'(dut.r_cnt), 0);
        p3 = 1'b0;
        #2;
        check("inhibit_te_drop", int'(p14), 0);

        // Divider case: TC tied to PE, P=3 -> period 4, width 1
        p9 = 1'b0; pdata = 8'h03;
        tick(1);
        p9 = 1'b1; tie = 1'b1;
        for (int i = 0; i < 24; i++) begin
            check("divider", int'(p14), (i % 4 == 3) ? 0 : 1);
            tick(1);
        end

        // P=00 tied: TC stuck low, count stuck at 0
        p9 = 1'b0; pdata = 8'h00;
        tick(1);
        p9 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("div0_tc", int'(p14), 0);
            check("div0_cnt", int'(dut.r_cnt), 0);
            tick(1);
        end
        tie = 1'b0;

        // Priority case
        p2 = 1'b1; p9 = 1'b0; pdata = 8'h10;
        tick(1);
        check("prio_rst_over_pl", int'(dut.r_cnt), 8'hFF);
        p2 = 1'b0; pe_drv = 1'b0; pdata = 8'h22;
        tick(1);
        check("prio_pl_pe", int'(dut.r_cnt), 8'h22);
        pe_drv = 1'b1; p3 = 1'b1; pdata = 8'h33;
        tick(1);
        check("prio_pl_te_high", int'(dut.r_cnt), 8'h33);
        p9 = 1'b1; p3 = 1'b0;

        // Mid-operation reset: next TC 255 enabled clocks after release
        p9 = 1'b0; pdata = 8'h03;
        tick(1);
        p9 = 1'b1;
        tick(2);
        check("mid_cnt_before", int'(dut.r_cnt), 8'h01);
        p2 = 1'b1;
        tick(1);
        check("mid_rst_tc", int'(p14), 1);
        check("mid_rst_cnt", int'(dut.r_cnt), 8'hFF);
        p2 = 1'b0;
        tick(254);
        check("mid_254", int'(p14), 1);
        tick(1);
        check("mid_255", int'(p14), 0);
        tick(2);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/hc40103.md
HC40103 -- requirements
Module: hc40103

Scope: 8-bit presettable synchronous down-counter, 74HC40103 pin-flavoured. It sits upstream of the hex D flip-flop stage: its p14 terminal-count strobe drives that stage's clock input, one strobe every N+1 clocks.

Interface
REQ-001 The block SHALL have no parameters; all behaviour is fixed.
REQ-002 p1  input  1  clock; all state changes on its rising edge; one clock only.
REQ-003 p2  input  1  reset (MR); synchronous, active-high.
REQ-004 p3  input  1  TE, terminal enable, active-low; low = count and TC enabled.
REQ-005 p4,p5,p6,p7  input  1 each  preset data P0..P3 (p4 = LSB).
REQ-006 p10,p11,p12,p13  input  1 each  preset data P4..P7 (p13 = MSB).
REQ-007 p9  input  1  PL, synchronous parallel load, active-low, TE-independent.
REQ-008 p15  input  1  PE, synchronous preset enable, active-low.
REQ-009 p14  output  1  TC, terminal count, active-low.
REQ-010 Pins p8 and p16 SHALL NOT exist as ports; they are supply pins.

Function
REQ-011 The internal state SHALL be an 8-bit register cnt, power-up value 8'hFF.
REQ-012 Per rising p1 edge, priority SHALL be p2 > p9 > p15 > count.
REQ-013 p2=1: cnt <= 8'hFF, regardless of every other input.
REQ-014 p2=0, p9=0: cnt <= P[7:0], regardless of p3 and p15.
REQ-015 p2=0, p9=1, p15=0: cnt <= P[7:0], regardless of p3.
REQ-016 p2=0, p9=1, p15=1, p3=0: cnt <= cnt - 1, modulo 256; 8'h00 wraps to 8'hFF.
REQ-017 p2=0, p9=1, p15=1, p3=1: cnt holds.
REQ-018 p14 SHALL be combinational: p14 = 0 exactly when cnt == 8'h00 and p3 == 0; otherwise 1.
REQ-019 p14 SHALL react to p3 within the same cycle, with zero clock latency.
REQ-020 Load latency: P SHALL be visible in cnt one clock after the loading edge.
REQ-021 With p14 tied to p15 and p3=0, TC SHALL be low for exactly 1 cycle in every N+1 cycles, where N = P.
REQ-022 With P = 8'h00 and p14 tied to p15, p14 SHALL stay low permanently and cnt SHALL stay at 0.
REQ-023 Preset data SHALL be sampled only at the loading edge; changes between loads have no effect.
REQ-024 No other state, output or latch SHALL exist.

Reset
REQ-025 Reset SHALL take effect only on a rising p1 edge while p2=1, with no asynchronous path.
REQ-026 After reset, cnt = 8'hFF, so p14 = 1 for any p3 value.
REQ-027 Reset asserted mid-count or mid-load SHALL override that operation on the same edge.
REQ-028 After p2 deasserts, counting SHALL resume from 8'hFF on the next enabled edge.

Verification
REQ-029 Reset case: p2=1 for 1 clock, p3=0 -> p14=1; with p9=p15=1, the 255th following clock gives p14=0, and the 256th gives p14=1 (wrap to FF).
REQ-030 Preset case: p15=0, P=8'h05, p3=0, 1 clock; then p15=1 -> p14 is low after exactly 5 clocks, for 1 cycle, then high.
REQ-031 Inhibit case: load 8'h00, p3=1 -> p14=1 and count holds over 10 clocks; drop p3 -> p14=0 with no clock edge.
REQ-032 Divider case: p14 wired to p15, P=8'h03, p3=0 -> p14 has a low pulse period of 4 clocks, pulse width 1 clock, sustained for at least 20 clocks.
REQ-033 Priority case: p2=1 with p9=0 and P=8'h10 -> cnt=FF; p9=0 with p15=0 and P=8'h22 -> cnt=22; p9=0 with p3=1 -> load still occurs.
REQ-034 Mid-operation reset case: load 8'h03, count 2 clocks, assert p2 for 1 clock -> p14=1, and the next terminal count arrives 255 enabled clocks after p2 deasserts.
